// File: rtl/matrix_loader_pkg.sv
// rtl/matrix_loader_pkg.sv - shared widths, header layout, targets and FSM encoding
package matrix_loader_pkg;

    localparam int DATA_W       = 32;
    localparam int DIM_W        = 10;

    localparam int HDR_FLD_W    = 10;
    localparam int HDR_ROWS_LSB = 0;
    localparam int HDR_COLS_LSB = 10;
    localparam int HDR_TGT_BIT  = 20;

    localparam logic TGT_INPUT  = 1'b0;
    localparam logic TGT_FILTER = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/matrix_loader_if.sv
// rtl/matrix_loader_if.sv - header/element stream in, element write port out
interface matrix_loader_if #(
    parameter int DATA_W = matrix_loader_pkg::DATA_W,
    parameter int DIM_W  = matrix_loader_pkg::DIM_W
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;

    logic              mem_we;
    logic              mem_sel;
    logic [DIM_W-1:0]  mem_row;
    logic [DIM_W-1:0]  mem_col;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output s_valid, s_data,
        input  s_ready, mem_we, mem_sel, mem_row, mem_col, mem_wdata
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, mem_we, mem_sel, mem_row, mem_col, mem_wdata
    );
endinterface

// File: rtl/matrix_index_counter.sv
// rtl/matrix_index_counter.sv - row-major row/col counter with load, enable and last flag
module matrix_index_counter #(
    parameter int DIM_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [DIM_W-1:0] rows,
    input  logic [DIM_W-1:0] cols,
    output logic [DIM_W-1:0] row,
    output logic [DIM_W-1:0] col,
    output logic             last
);
    logic [DIM_W-1:0] row_q;
    logic [DIM_W-1:0] col_q;
    logic             row_last;
    logic             col_last;

    assign row_last = (row_q == rows - DIM_W'(1));
    assign col_last = (col_q == cols - DIM_W'(1));
    assign last     = row_last & col_last;
    assign row      = row_q;
    assign col      = col_q;

    // Returning to (0,0) after the final element keeps the indices inside the matrix.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q <= '0;
            col_q <= '0;
        end else if (load) begin
            row_q <= '0;
            col_q <= '0;
        end else if (en) begin
            if (col_last) begin
                col_q <= '0;
                row_q <= row_last ? '0 : row_q + DIM_W'(1);
            end else begin
                col_q <= col_q + DIM_W'(1);
            end
        end
    end
endmodule

// File: rtl/matrix_loader.sv
// rtl/matrix_loader.sv - parses a matrix header and streams its elements into input/filter memory
module matrix_loader #(
    parameter int DATA_W = matrix_loader_pkg::DATA_W,
    parameter int DIM_W  = matrix_loader_pkg::DIM_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    matrix_loader_if.slave bus,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic           input_loaded,
    output logic           filter_loaded
);
    import matrix_loader_pkg::*;

    state_e            state_q, state_d;
    logic [DIM_W-1:0]  rows_q, rows_d, cols_q, cols_d;
    logic              tgt_q, tgt_d;
    logic              mem_we_q, mem_we_d, mem_sel_q, mem_sel_d;
    logic [DIM_W-1:0]  mem_row_q, mem_row_d, mem_col_q, mem_col_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              done_q, done_d, err_q, err_d;
    logic              in_q, in_d, fl_q, fl_d;

    logic              xfer, hdr_ok, hdr_tgt;
    logic [DIM_W-1:0]  hdr_rows, hdr_cols;
    logic              cnt_load, cnt_en, cnt_last;
    logic [DIM_W-1:0]  cnt_row, cnt_col;
    logic              unused_hdr;

    assign bus.s_ready = rst & (state_q != ST_FIN);
    assign xfer        = bus.s_valid & bus.s_ready;
    assign hdr_rows    = DIM_W'(bus.s_data[HDR_ROWS_LSB +: HDR_FLD_W]);
    assign hdr_cols    = DIM_W'(bus.s_data[HDR_COLS_LSB +: HDR_FLD_W]);
    assign hdr_tgt     = bus.s_data[HDR_TGT_BIT];
    assign hdr_ok      = (|hdr_rows) & (|hdr_cols);
    assign unused_hdr  = ^bus.s_data[DATA_W-1:HDR_TGT_BIT+1];

    matrix_index_counter #(.DIM_W(DIM_W)) u_idx (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .en   (cnt_en),
        .rows (rows_q),
        .cols (cols_q),
        .row  (cnt_row),
        .col  (cnt_col),
        .last (cnt_last)
    );

    // clr is applied first so a FIN set below overrides it for the selected flag.
    always_comb begin
        state_d     = state_q;
        rows_d      = rows_q;
        cols_d      = cols_q;
        tgt_d       = tgt_q;
        cnt_load    = 1'b0;
        cnt_en      = 1'b0;
        mem_we_d    = 1'b0;
        mem_sel_d   = mem_sel_q;
        mem_row_d   = mem_row_q;
        mem_col_d   = mem_col_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        in_d        = clr ? 1'b0 : in_q;
        fl_d        = clr ? 1'b0 : fl_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    if (hdr_ok) begin
                        rows_d   = hdr_rows;
                        cols_d   = hdr_cols;
                        tgt_d    = hdr_tgt;
                        cnt_load = 1'b1;
                        state_d  = ST_LOAD;
                        if (hdr_tgt == TGT_INPUT) in_d = 1'b0;
                        else                      fl_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    cnt_en      = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_sel_d   = tgt_q;
                    mem_row_d   = cnt_row;
                    mem_col_d   = cnt_col;
                    mem_wdata_d = bus.s_data;
                    if (cnt_last) state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
                if (tgt_q == TGT_INPUT) in_d = 1'b1;
                else                    fl_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            rows_q      <= '0;
            cols_q      <= '0;
            tgt_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_sel_q   <= 1'b0;
            mem_row_q   <= '0;
            mem_col_q   <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            in_q        <= 1'b0;
            fl_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            rows_q      <= rows_d;
            cols_q      <= cols_d;
            tgt_q       <= tgt_d;
            mem_we_q    <= mem_we_d;
            mem_sel_q   <= mem_sel_d;
            mem_row_q   <= mem_row_d;
            mem_col_q   <= mem_col_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
            in_q        <= in_d;
            fl_q        <= fl_d;
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_sel   = mem_sel_q;
    assign bus.mem_row   = mem_row_q;
    assign bus.mem_col   = mem_col_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign busy          = (state_q == ST_LOAD);
    assign done          = done_q;
    assign err           = err_q;
    assign input_loaded  = in_q;
    assign filter_loaded = fl_q;
endmodule

// File: tb/tb_matrix_loader.sv
// tb/tb_matrix_loader.sv - randomized and directed checks of matrix_loader against a write-list model
module tb_matrix_loader;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clr = 1'b0;
    logic busy, done, err, input_loaded, filter_loaded;

    matrix_loader_if #(.DATA_W(32), .DIM_W(10)) bus();

    matrix_loader #(.DATA_W(32), .DIM_W(10)) dut (
        .clk           (clk),
        .rst           (rst),
        .clr           (clr),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .input_loaded  (input_loaded),
        .filter_loaded (filter_loaded)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          done_cnt = 0, err_cnt = 0, last_we_cyc = 0, done_cyc = 0;
    int          n_cmp = 0, n_bad = 0;
    bit          exp_flag [2];
    logic [52:0] wq [$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.mem_we) begin
            wq.push_back({bus.mem_sel, bus.mem_row, bus.mem_col, bus.mem_wdata});
            last_we_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (err) err_cnt++;
    end

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.s_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic push(input logic [31:0] w);
        bit ok;
        bus.s_valid = 1'b1;
        bus.s_data  = w;
        for (int n = 0; n < 64; n++) begin
            ok = bus.s_ready;
            step();
            if (ok) return;
        end
        expect_eq("push_timeout", 64'd0, 64'd1);
    endtask

    function automatic logic [52:0] ent(input bit sel, input int r, input int c, input logic [31:0] d);
        return {sel, 10'(r), 10'(c), d};
    endfunction

    task automatic check_flags(input string tag);
        expect_eq({tag, "_input_loaded"}, 64'(input_loaded), 64'(exp_flag[0]));
        expect_eq({tag, "_filter_loaded"}, 64'(filter_loaded), 64'(exp_flag[1]));
    endtask

    task automatic check_all_zero(input string tag);
        expect_eq(tag, {bus.s_ready, busy, done, err, bus.mem_we, bus.mem_sel, input_loaded,
                        filter_loaded, bus.mem_row, bus.mem_col, bus.mem_wdata}, 64'd0);
    endtask

    // gap_mode: 0 back-to-back, 1 one idle cycle between elements, 2 random idles
    task automatic load(input int rows, input int cols, input bit tgt, input int gap_mode,
                        input bit seq_data, input bit clr_at_fin);
        logic [52:0] exp [$];
        logic [31:0] d [$];
        logic [31:0] dv, hdr;
        int          d0, e0, n;
        wq.delete();
        d0 = done_cnt;
        e0 = err_cnt;
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols; c++) begin
                dv = seq_data ? 32'(r * cols + c + 1) : $urandom;
                d.push_back(dv);
                exp.push_back(ent(tgt, r, c, dv));
            end
        hdr        = $urandom;
        hdr[9:0]   = rows[9:0];
        hdr[19:10] = cols[9:0];
        hdr[20]    = tgt;
        push(hdr);
        if (rows == 0 || cols == 0) begin
            bus.s_valid = 1'b0;
            expect_eq("err_pulse", 64'(err_cnt - e0), 64'd1);
            expect_eq("err_busy", 64'(busy), 64'd0);
            step();
            step();
            expect_eq("err_no_write", 64'(wq.size()), 64'd0);
            expect_eq("err_once", 64'(err_cnt - e0), 64'd1);
            check_flags("err");
            return;
        end
        exp_flag[tgt] = 1'b0;
        expect_eq("hdr_flag_clear", 64'(tgt ? filter_loaded : input_loaded), 64'd0);
        expect_eq("hdr_busy", 64'(busy), 64'd1);
        for (int i = 0; i < d.size(); i++) begin
            if (gap_mode == 1 && i > 0) idle(1);
            if (gap_mode == 2) idle($urandom_range(0, 2));
            push(d[i]);
        end
        bus.s_valid = 1'b0;
        expect_eq("fin_ready_low", 64'(bus.s_ready), 64'd0);
        if (clr_at_fin) begin
            clr = 1'b1;
            step();
            clr = 1'b0;
            exp_flag[0] = 1'b0;
            exp_flag[1] = 1'b0;
        end
        exp_flag[tgt] = 1'b1;
        n = 0;
        while (done_cnt == d0 && n < 20) begin
            step();
            n++;
        end
        expect_eq("done_seen", 64'(done_cnt - d0), 64'd1);
        expect_eq("done_latency", 64'(done_cyc - last_we_cyc), 64'd1);
        expect_eq("n_writes", 64'(wq.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < wq.size(); i++)
            expect_eq($sformatf("write[%0d]", i), 64'(wq[i]), 64'(exp[i]));
        check_flags("fin");
        step();
        expect_eq("post_busy", 64'(busy), 64'd0);
        expect_eq("post_done_once", 64'(done_cnt - d0), 64'd1);
        expect_eq("mem_hold", {bus.mem_we, bus.mem_sel, bus.mem_row, bus.mem_col, bus.mem_wdata},
                  {1'b0, exp[exp.size()-1]});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        exp_flag[0] = 1'b0;
        exp_flag[1] = 1'b0;
        step();
        step();
        check_all_zero("reset_outputs");
        rst = 1'b1;
        step();
        expect_eq("ready_after_reset", 64'(bus.s_ready), 64'd1);

        load(2, 3, 1'b0, 0, 1'b1, 1'b0);
        load(2, 3, 1'b0, 1, 1'b1, 1'b0);
        load(0, 5, 1'b0, 0, 1'b1, 1'b0);
        load(1, 1, 1'b1, 0, 1'b1, 1'b0);

        // reset in the middle of a 2x3 input load
        wq.delete();
        push({11'd0, 1'b0, 10'd3, 10'd2});
        exp_flag[0] = 1'b0;
        for (int i = 0; i < 3; i++) push(32'(i + 100));
        bus.s_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("midload_reset");
        exp_flag[0] = 1'b0;
        exp_flag[1] = 1'b0;
        step();
        rst = 1'b1;
        step();
        expect_eq("ready_after_release", 64'(bus.s_ready), 64'd1);
        check_flags("after_release");
        load(1, 2, 1'b0, 0, 1'b0, 1'b0);

        load(1, 2, 1'b1, 0, 1'b0, 1'b1);
        load(1, 1, 1'b0, 0, 1'b0, 1'b0);
        load(2, 2, 1'b0, 2, 1'b0, 1'b0);

        load(1023, 1, 1'b1, 0, 1'b0, 1'b0);
        load(1, 1023, 1'b0, 0, 1'b0, 1'b0);
        load(3, 0, 1'b1, 0, 1'b0, 1'b0);

        repeat (30) begin
            load($urandom_range(0, 5), $urandom_range(0, 5), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 2), 1'b0, ($urandom_range(0, 3) == 0));
            idle($urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
